// File: rtl/phase_timer.sv
// Seconds countdown pacing the traffic-light FSM; emits a one-cycle advance strobe when a phase expires.
// Latency: advance one edge after enable/expiry/preempt; a phase of N s spans N*TICK_DIV+2 cycles between strobes.
// Backpressure: none; hold freezes the countdown, enable=0 parks in IDLE, preempt cuts the current phase short.
module phase_timer #(
    parameter int TICK_DIV = 10000,
    parameter int TIMER_W  = 8,
    parameter int PRE_W    = 14
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               hold,
    input  logic               preempt,
    input  logic [TIMER_W-1:0] timer_in,
    output logic               advance,
    output logic               sec_tick,
    output logic [TIMER_W-1:0] remaining,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        LOAD    = 2'd2,
        COUNT   = 2'd3
    } state_t;

    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]   PRE_ONE  = PRE_W'(1);
    localparam logic [TIMER_W-1:0] REM_ONE  = TIMER_W'(1);

    state_t           state;
    logic [PRE_W-1:0] prescaler;

    // Phase sequencing, prescaler/second countdown and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prescaler <= '0;
            remaining <= '0;
            advance   <= 1'b0;
            sec_tick  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            advance  <= 1'b0;
            sec_tick <= 1'b0;
            if (!enable) begin
                // Disable wins over everything, including a strobe in flight.
                state     <= IDLE;
                prescaler <= '0;
                remaining <= '0;
                busy      <= 1'b0;
            end else begin
                busy <= 1'b1;
                case (state)
                    IDLE: begin
                        state   <= ADVANCE;
                        advance <= 1'b1;
                    end
                    ADVANCE: begin
                        // The light FSM updates timer_in on this closing edge.
                        state <= LOAD;
                    end
                    LOAD: begin
                        remaining <= timer_in;
                        prescaler <= '0;
                        if (timer_in == '0) begin
                            // Zero-length phase: skip straight to the next advance.
                            state   <= ADVANCE;
                            advance <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (preempt) begin
                            // Sensor event ends the phase; the partial second is dropped.
                            state     <= ADVANCE;
                            advance   <= 1'b1;
                            remaining <= '0;
                            prescaler <= '0;
                        end else if (!hold) begin
                            if (prescaler == PRE_LAST) begin
                                prescaler <= '0;
                                if (remaining != '0) begin
                                    sec_tick  <= 1'b1;
                                    remaining <= remaining - REM_ONE;
                                end
                                if (remaining == REM_ONE) begin
                                    state   <= ADVANCE;
                                    advance <= 1'b1;
                                end
                            end else begin
                                prescaler <= prescaler + PRE_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
- Seconds countdown that paces the intersection traffic-light state machine.
- Sits beside the light FSM in a closed loop. It consumes the FSM's per-phase duration (timer, in seconds) and counts it down using the 10 kHz system clock. When the phase expires, it emits the one-cycle advance strobe that drives the FSM's clock_reset step input.
- It also supports sensor-driven pre-emption and a freeze/hold for maintenance.

Parameters:
- TICK_DIV, 10000, clk cycles per second (10 kHz clock); bench uses 4.
- TIMER_W, 8, width of duration/remaining count (matches FSM timer).
- PRE_W, 14, prescaler width; must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, 10 kHz.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run; low parks the block in IDLE.
- hold  in  1  level; freezes prescaler and remaining count.
- preempt  in  1  one-cycle request to end the current phase immediately (sensor event).
- timer_in  in  TIMER_W  phase duration in seconds, from FSM timer output.
- advance  out  1  registered one-cycle strobe to FSM clock_reset.
- sec_tick  out  1  registered one-cycle pulse each elapsed second.
- remaining  out  TIMER_W  seconds left in current phase.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, prescaler=0, remaining=0.
  - advance=0, sec_tick=0, busy=0.
- States: IDLE, ADVANCE, LOAD, COUNT.
- IDLE:
  - Outputs 0.
  - enable=1 at an edge → ADVANCE.
- ADVANCE:
  - advance=1 for exactly this cycle.
  - The FSM updates timer on the closing edge.
  - Next state: LOAD.
- LOAD:
  - advance=0.
  - Closing edge: remaining<=timer_in, prescaler<=0.
  - timer_in==0 → ADVANCE (zero-length phase skipped, no sec_tick); else → COUNT.
- COUNT:
  - Each edge with hold=0: prescaler increments.
  - At prescaler==TICK_DIV-1: prescaler<=0, sec_tick=1 next cycle, remaining<=remaining-1.
  - If remaining==1 at that edge → ADVANCE.
- Phase period: advance pulses are spaced exactly N*TICK_DIV+2 cycles apart for duration N≥1, and 2 cycles apart for N=0.
- hold=1 in COUNT:
  - prescaler and remaining are frozen and no sec_tick is issued.
  - hold has no effect in ADVANCE/LOAD; those always complete.
- preempt=1 in COUNT → ADVANCE at the next edge, regardless of hold.
  - remaining<=0.
  - No sec_tick is issued for the partial second.
  - preempt is ignored in IDLE/ADVANCE/LOAD.
- Priority at the same edge: enable=0 > preempt > hold > normal countdown.
- enable=0 in any state → IDLE at the next edge, prescaler and remaining cleared. This applies even mid-ADVANCE (the strobe is not extended).
- Arithmetic:
  - remaining never wraps; decrement occurs only when remaining≥1.
  - prescaler never exceeds TICK_DIV-1.
  - timer_in=255 is legal (255 s).
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-COUNT: immediate clear. After release, restart requires enable at an edge (first advance one cycle later).

Test Plan:
- TICK_DIV=4, reset then enable=1, FSM model returns timer_in=3 → advance at cycle 1; remaining=3 then 2,1,0; sec_tick every 4 cycles; next advance 14 cycles after the first.
- timer_in sequence 17,3,1,55 → advance gaps 70,14,6,222 cycles; busy=1 throughout.
- timer_in=0 → advance pulses 2 cycles apart, no sec_tick, remaining=0.
- timer_in=5, hold=1 for 10 cycles mid-count → remaining frozen; advance delayed by exactly 10 cycles (gap 32).
- timer_in=110, preempt pulse at remaining=107 → advance on the following cycle, remaining=0; preempt while hold=1 also advances.
- reset_n low mid-COUNT (async, between edges) → all outputs 0 immediately. enable=0 mid-count → IDLE next edge, no advance; re-enable → advance one cycle later.
